dmem_responder: RTL and testbench

Data-memory responder for the five-stage pipelined CPU. It is the memory end of the CPU's `d_addr`/`d_we`/`d_dataout`/`d_datain` port, built on a 256×16 array. It also has a second, handshaked host port, used by the test/debug harness to preload and dump data memory while the CPU runs or idles. An optional post-reset clear sweep zeroes the array before the memory reports ready.

---
 rtl/dmem_responder.sv | 134 +++++++++++++
 tb/tb_dmem_responder.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: combinational CPU load/store port plus a handshaked host port on one array.
// Optional post-reset clear sweep enabled by defining DMEM_CLR_SWEEP_EN.
module dmem_responder #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [AW-1:0] d_addr,
    input  logic          d_we,
    input  logic [DW-1:0] d_dataout,
    output logic [DW-1:0] d_datain,
    input  logic          h_req,
    input  logic          h_we,
    input  logic [AW-1:0] h_addr,
    input  logic [DW-1:0] h_wdata,
    output logic          h_ack,
    output logic [DW-1:0] h_rdata,
    output logic          ready,
    output logic          drop
);

    localparam int unsigned DEPTH = 2 ** AW;

    typedef enum logic {H_IDLE, H_ACK} h_state_e;

    logic [DW-1:0] mem [DEPTH];

    h_state_e      h_state_q, h_state_d;
    logic          h_ack_q;
    logic [DW-1:0] h_rdata_q;
    logic          run_c;
    logic          accept_c;
    logic          cpu_wr_c;
    logic          host_wr_c;
    logic          host_rd_c;

`ifdef DMEM_CLR_SWEEP_EN
    typedef enum logic {TOP_SWEEP, TOP_RUN} top_state_e;

    top_state_e    top_state_q, top_state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          drop_q, drop_d;

    // Top-level state register: sweep counter and sticky drop flag
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            top_state_q <= TOP_SWEEP;
            cnt_q       <= '0;
            drop_q      <= 1'b0;
        end else begin
            top_state_q <= top_state_d;
            cnt_q       <= cnt_d;
            drop_q      <= drop_d;
        end
    end

    always_comb begin
        top_state_d = top_state_q;
        cnt_d       = cnt_q;
        drop_d      = drop_q;
        if (top_state_q == TOP_SWEEP) begin
            cnt_d = cnt_q + AW'(1);
            if (d_we) begin
                drop_d = 1'b1;
            end
            if (cnt_q == '1) begin
                top_state_d = TOP_RUN;
            end
        end
    end

    assign run_c = (top_state_q == TOP_RUN);
    assign ready = run_c;
    assign drop  = drop_q;
`else
    assign run_c = 1'b1;
    assign ready = 1'b1;
    assign drop  = 1'b0;
`endif

    // Host sub-FSM next state; CPU writes take priority over host writes only
    always_comb begin
        h_state_d = h_state_q;
        accept_c  = 1'b0;
        case (h_state_q)
            H_IDLE: begin
                if (run_c && h_req && !(h_we && d_we)) begin
                    accept_c  = 1'b1;
                    h_state_d = H_ACK;
                end
            end
            H_ACK:   h_state_d = H_IDLE;
            default: h_state_d = H_IDLE;
        endcase
    end

    assign cpu_wr_c  = run_c && d_we;
    assign host_wr_c = accept_c && h_we;
    assign host_rd_c = accept_c && !h_we;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            h_state_q <= H_IDLE;
            h_ack_q   <= 1'b0;
            h_rdata_q <= '0;
        end else begin
            h_state_q <= h_state_d;
            h_ack_q   <= accept_c;
            if (host_rd_c) begin
                h_rdata_q <= mem[h_addr];
            end
        end
    end

    // Array write port; CPU and host writes are mutually exclusive by the acceptance rule
    always_ff @(posedge clock) begin
        if (cpu_wr_c) begin
            mem[d_addr] <= d_dataout;
        end else if (host_wr_c) begin
            mem[h_addr] <= h_wdata;
        end
`ifdef DMEM_CLR_SWEEP_EN
        if (!run_c) begin
            mem[cnt_q] <= '0;
        end
`endif
    end

    assign d_datain = run_c ? mem[d_addr] : '0;
    assign h_ack    = h_ack_q;
    assign h_rdata  = h_rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus random CPU/host traffic
// against an array-based reference model.
module tb_dmem_responder;

    localparam int unsigned AW    = 8;
    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 256;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [AW-1:0] d_addr;
    logic          d_we;
    logic [DW-1:0] d_dataout;
    logic [DW-1:0] d_datain;
    logic          h_req;
    logic          h_we;
    logic [AW-1:0] h_addr;
    logic [DW-1:0] h_wdata;
    logic          h_ack;
    logic [DW-1:0] h_rdata;
    logic          ready;
    logic          drop;

    always #5 clock = ~clock;

    dmem_responder #(.AW(AW), .DW(DW)) dut (
        .clock     (clock),
        .reset     (reset),
        .d_addr    (d_addr),
        .d_we      (d_we),
        .d_dataout (d_dataout),
        .d_datain  (d_datain),
        .h_req     (h_req),
        .h_we      (h_we),
        .h_addr    (h_addr),
        .h_wdata   (h_wdata),
        .h_ack     (h_ack),
        .h_rdata   (h_rdata),
        .ready     (ready),
        .drop      (drop)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: memory contents, which words are defined, and outstanding host transaction
    logic [DW-1:0] ref_mem [DEPTH];
    bit            known   [DEPTH];
    bit            busy        = 1'b0;
    bit            ack_pending = 1'b0;
    bit            cur_we      = 1'b0;
    logic [DW-1:0] exp_rdata   = '0;
    int            lat         = 0;
    int            last_lat    = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic host_start(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
        h_req   = 1'b1;
        h_we    = we;
        h_addr  = a;
        h_wdata = wd;
        busy    = 1'b1;
        lat     = 0;
    endtask

    // One clock cycle with current inputs: check load data, apply the edge to the model, check host outputs
    task automatic tick();
        #1;
        if (known[d_addr]) check_eq("d_datain", d_datain, ref_mem[d_addr]);
        @(posedge clock);
        if (busy) lat++;
        if (ack_pending) begin
            ack_pending = 1'b0;
        end else if (h_req && !(h_we && d_we)) begin
            ack_pending = 1'b1;
            cur_we      = h_we;
            if (!h_we) begin
                exp_rdata = ref_mem[h_addr];
            end else begin
                ref_mem[h_addr] = h_wdata;
                known[h_addr]   = 1'b1;
            end
        end
        if (d_we) begin
            ref_mem[d_addr] = d_dataout;
            known[d_addr]   = 1'b1;
        end
        #1;
        check_eq("h_ack", h_ack, ack_pending);
        if (ack_pending && !cur_we) check_eq("h_rdata", h_rdata, exp_rdata);
        if (ack_pending) begin
            h_req    = 1'b0;
            busy     = 1'b0;
            last_lat = lat;
        end
    endtask

    task automatic wait_ack(input int max_cycles);
        int n = 0;
        while (busy && n < max_cycles) begin
            tick();
            n++;
        end
        check_eq("ack_timeout", busy, 0);
        if (busy) begin
            h_req = 1'b0;
            busy  = 1'b0;
        end
    endtask

    // Full host transaction followed by one idle cycle so the next request starts from idle
    task automatic host_txn(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
        host_start(we, a, wd);
        wait_ack(20);
        tick();
    endtask

`ifdef DMEM_CLR_SWEEP_EN
    // Count cycles until ready; optionally attempt a CPU write during the sweep
    task automatic sweep_wait(input bit poke);
        int n = 0;
        while (!ready && n < 1000) begin
            @(posedge clock);
            #1;
            n++;
            if (n == 5) begin
                d_addr = 8'h05;
                #1;
                check_eq("sweep_rd_zero", d_datain, 0);
            end
            if (poke && n == 9) begin
                d_we      = 1'b1;
                d_addr    = 8'h03;
                d_dataout = 16'hFFFF;
            end
            if (n == 10) d_we = 1'b0;
        end
        check_eq("sweep_len", n, DEPTH);
        check_eq("sweep_drop", drop, {31'd0, poke});
        for (int i = 0; i < int'(DEPTH); i++) begin
            ref_mem[i] = '0;
            known[i]   = 1'b1;
        end
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] v;
        d_addr    = '0;
        d_we      = 1'b0;
        d_dataout = '0;
        h_req     = 1'b0;
        h_we      = 1'b0;
        h_addr    = '0;
        h_wdata   = '0;

        #3;
        check_eq("rst_h_ack", h_ack, 0);
        check_eq("rst_h_rdata", h_rdata, 0);
        check_eq("rst_drop", drop, 0);
`ifdef DMEM_CLR_SWEEP_EN
        check_eq("rst_ready", ready, 0);
`else
        check_eq("rst_ready", ready, 1);
`endif
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b1;

`ifdef DMEM_CLR_SWEEP_EN
        sweep_wait(1'b1);
        for (int a = 0; a < int'(DEPTH); a++) begin
            d_addr = AW'(a);
            tick();
        end
`endif
        check_eq("run_ready", ready, 1);

        // Preload every word through the host port
        for (int a = 0; a < int'(DEPTH); a++) begin
            host_txn(1'b1, AW'(a), DW'($urandom));
        end

        // Host write then read back
        host_txn(1'b1, 8'h05, 16'h1234);
        check_eq("wr_lat", last_lat, 1);
        host_txn(1'b0, 8'h05, 16'h0000);
        check_eq("rd_lat", last_lat, 1);
        check_eq("rd_0x05", h_rdata, 16'h1234);

        // CPU store then load of the same address
        v = ref_mem[8'h10];
        d_we = 1'b1; d_addr = 8'h10; d_dataout = 16'hBEEF;
        #1;
        check_eq("cpu_old_val", d_datain, v);
        tick();
        d_we = 1'b0;
        #1;
        check_eq("cpu_store_vis", d_datain, 16'hBEEF);
        tick();

        // Host write deferred by three consecutive CPU write cycles
        v = DW'($urandom);
        host_start(1'b1, 8'h20, v);
        for (int i = 0; i < 3; i++) begin
            d_we = 1'b1; d_addr = AW'(8'h40 + i); d_dataout = DW'($urandom);
            tick();
        end
        d_we = 1'b0;
        wait_ack(20);
        check_eq("defer_lat", last_lat, 4);
        tick();
        host_txn(1'b0, 8'h20, 16'h0000);
        check_eq("defer_data", h_rdata, v);

        // Host read at the same edge as a CPU write to that address
        host_txn(1'b1, 8'h30, 16'h0001);
        host_start(1'b0, 8'h30, 16'h0000);
        d_we = 1'b1; d_addr = 8'h30; d_dataout = 16'h5555;
        tick();
        d_we = 1'b0;
        check_eq("rdw_lat", last_lat, 1);
        check_eq("rdw_old", h_rdata, 16'h0001);
        tick();
        host_txn(1'b0, 8'h30, 16'h0000);
        check_eq("rdw_new", h_rdata, 16'h5555);

        // Random mixed traffic
        for (int i = 0; i < 1500; i++) begin
            d_we      = ($urandom % 3) == 0;
            d_addr    = ($urandom % 2) ? AW'($urandom % 16) : AW'($urandom);
            d_dataout = DW'($urandom);
            if (!busy && ($urandom % 2)) begin
                host_start(bit'($urandom % 2),
                           ($urandom % 2) ? AW'($urandom % 16) : AW'($urandom),
                           DW'($urandom));
            end
            tick();
        end
        d_we = 1'b0;
        wait_ack(100);
        tick();

        // Reset while a host request is waiting to be accepted
        host_start(1'b0, 8'h05, 16'h0000);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            check_eq("rst_mid_ack", h_ack, 0);
        end
        h_req       = 1'b0;
        busy        = 1'b0;
        ack_pending = 1'b0;
        reset       = 1'b1;
`ifdef DMEM_CLR_SWEEP_EN
        sweep_wait(1'b0);
`endif
        check_eq("post_rst_drop", drop, 0);
        tick();
        check_eq("post_rst_ack", h_ack, 0);
        host_txn(1'b0, 8'h05, 16'h0000);
        check_eq("post_rst_lat", last_lat, 1);
        host_txn(1'b1, 8'h06, 16'hA5A5);
        host_txn(1'b0, 8'h06, 16'h0000);
        check_eq("post_rst_rd", h_rdata, 16'hA5A5);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
